seven_seg_scan_ctrl: RTL

Scan controller that time-multiplexes the six-digit seven-segment display. It drives the 3-bit digit select of the segment/anode mux. Each digit slot begins with a blanking dead-time (anti-ghosting), then a lit window whose length is set by a brightness value. Per-digit enables allow leading-zero or unused-digit blanking, and a frame pulse marks each completed scan.

---
 rtl/seven_seg_scan_ctrl_pkg.sv | 7 +
 rtl/seven_seg_scan_ctrl_slot_timer.sv | 35 +++
 rtl/seven_seg_scan_ctrl.sv | 65 ++++++
 3 files changed

// File: rtl/seven_seg_scan_ctrl_pkg.sv
// seven_seg_pkg: shared constants and types for the seven-segment scan controller.
package seven_seg_pkg;
  localparam int NUM_DIGITS = 6;
  localparam logic [2:0] SEL_BLANK = 3'd7;
  typedef logic [2:0] digit_idx_t;
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} scan_state_t;
endpackage

// File: rtl/seven_seg_scan_ctrl_slot_timer.sv
// seg_slot_timer: slot cycle counter and digit pointer with slot boundary strobes.
module seg_slot_timer
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 20000,
  parameter int BLANK_CYCLES = 200,
  parameter int CW           = $clog2(REFRESH_DIV)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          start,
  output logic [CW-1:0] c,
  output digit_idx_t    d,
  output logic          slot_start,
  output logic          blank_end,
  output logic          slot_end
);
  assign slot_end   = c == CW'(REFRESH_DIV - 1);
  assign blank_end  = c == CW'(BLANK_CYCLES - 1);
  assign slot_start = start | slot_end;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      c <= '0;
      d <= '0;
    end else if (clr) begin
      c <= '0;
      d <= '0;
    end else if (slot_end) begin
      c <= '0;
      d <= (d == digit_idx_t'(NUM_DIGITS - 1)) ? '0 : d + 3'd1;
    end else begin
      c <= c + 1'b1;
    end
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: six-digit scan FSM with blanking dead-time and PWM lit window.
// Define SEG_SCAN_BRIGHTNESS_EN to enable the brightness-controlled duty; otherwise the whole post-blank window is lit.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 20000,
  parameter int BLANK_CYCLES = 200
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [NUM_DIGITS-1:0] digit_en,
  input  logic [3:0]            brightness,
  output logic [2:0]            sel,
  output logic                  frame_tick
);
  localparam int CW   = $clog2(REFRESH_DIV);
  localparam int SPAN = REFRESH_DIV - BLANK_CYCLES;
  scan_state_t state, nxt;
  logic [NUM_DIGITS-1:0] me;
  logic [CW-1:0] c;
  digit_idx_t d;
  logic slot_start, blank_end, slot_end;
  logic [31:0] on;
  seg_slot_timer #(.REFRESH_DIV(REFRESH_DIV), .BLANK_CYCLES(BLANK_CYCLES), .CW(CW)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (state == IDLE || !enable),
    .start      (state == IDLE && enable),
    .c          (c),
    .d          (d),
    .slot_start (slot_start),
    .blank_end  (blank_end),
    .slot_end   (slot_end)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (!enable) nxt = IDLE;
    else if (state == IDLE) nxt = BLANK;
    else if (state == BLANK && blank_end) nxt = SHOW;
    else if (state == SHOW && slot_end) nxt = BLANK;
  end
  // Mask and duty only change at a slot boundary so a slot never splits mid-way.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) me <= '0;
    else if (slot_start) me <= digit_en;
`ifdef SEG_SCAN_BRIGHTNESS_EN
  logic [3:0] bl;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bl <= '0;
    else if (slot_start) bl <= brightness;
  assign on = 32'((64'(SPAN) * (64'(bl) + 64'd1)) >> 4);
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign on = 32'(SPAN);
`endif
  always_comb begin
    sel = (state == SHOW && me[d] && 32'(c) < 32'(BLANK_CYCLES) + on) ? d : SEL_BLANK;
    frame_tick = state == SHOW && slot_end && d == digit_idx_t'(NUM_DIGITS - 1);
  end
endmodule
